// File: rtl/sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// sub_bytes_seq : multi-cycle AES SubBytes, LANES S-box lookups per cycle.
// Optional inverse lanes under macro SUB_BYTES_INV_EN.          Rev 1.0
// ============================================================================
module sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
`ifdef SUB_BYTES_INV_EN
  input  logic         inv_mode,
`endif
  output logic         busy
);
  localparam int NCHUNK  = 16 / LANES;
  localparam int CHUNK_W = 8 * LANES;
  localparam int CW      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  // Entry 0 sits in the top byte, so the table reads like the FIPS-197 grid.
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    return SBOX_FWD[{~b, 3'b000} +: 8];
  endfunction

`ifdef SUB_BYTES_INV_EN
  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    return SBOX_INV[{~b, 3'b000} +: 8];
  endfunction

  logic inv_q;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [127:0]        work;
  logic [CW-1:0]       cnt;
  logic [6:0]          chunk_lo;
  logic [CHUNK_W-1:0]  chunk_in;
  logic [CHUNK_W-1:0]  chunk_out;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign out_data  = work;

  // Chunk 0 holds byte 0, which lives at the top of the word.
  assign chunk_lo = 7'(128 - CHUNK_W * (int'(cnt) + 1));
  assign chunk_in = work[chunk_lo +: CHUNK_W];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] lane_in;
    assign lane_in = chunk_in[CHUNK_W-1-8*l -: 8];
`ifdef SUB_BYTES_INV_EN
    assign chunk_out[CHUNK_W-1-8*l -: 8] = inv_q ? sbox_inv(lane_in) : sbox_fwd(lane_in);
`else
    assign chunk_out[CHUNK_W-1-8*l -: 8] = sbox_fwd(lane_in);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = BUSY;
      BUSY:    if (cnt == LAST) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work  <= '0;
      cnt   <= '0;
`ifdef SUB_BYTES_INV_EN
      inv_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          work  <= in_data;
          cnt   <= '0;
`ifdef SUB_BYTES_INV_EN
          inv_q <= inv_mode;
`endif
        end
        BUSY: begin
          work[chunk_lo +: CHUNK_W] <= chunk_out;
          if (cnt != LAST) cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sub_bytes_seq.sv
`default_nettype none
// tb_sub_bytes_seq: directed and random SubBytes blocks checked against an
// S-box model derived from GF(2^8) inversion plus the AES affine transform.
module tb_sub_bytes_seq;
  localparam int LANES  = 4;
  localparam int NCHUNK = 16 / LANES;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
`ifdef SUB_BYTES_INV_EN
  logic         inv_mode;
`endif

  always #5 clk = ~clk;

  sub_bytes_seq #(.LANES(LANES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef SUB_BYTES_INV_EN
    .inv_mode  (inv_mode),
`endif
    .busy      (busy)
  );

  logic [7:0]   fwd_t [256];
  logic [7:0]   inv_t [256];
  logic [127:0] exp_q [$];
  int           n_vec = 0;
  int           n_err = 0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d, input bit inv);
    logic [127:0] r;
    logic [7:0]   b;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      b = d[127-8*k -: 8];
      r[127-8*k -: 8] = inv ? inv_t[b] : fwd_t[b];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Scoreboard monitor: every completed output handshake pops one expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got %h, required no output", out_data);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic run_block(input logic [127:0] d, input logic [127:0] want,
                           input bit inv, input int hold);
    int           lat;
    int           w;
    logic [127:0] held;
    out_ready = (hold == 0);
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check("in_ready_idle", {127'd0, in_ready}, 128'd1);
    in_valid = 1'b1;
    in_data  = d;
`ifdef SUB_BYTES_INV_EN
    inv_mode = inv;
`endif
    @(posedge clk);
    exp_q.push_back(want);
    #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
`ifdef SUB_BYTES_INV_EN
    inv_mode = ~inv;
`endif
    lat = 0;
    do begin
      check("busy", {127'd0, busy}, 128'd1);
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 40);
    check("latency", 128'(lat), 128'(NCHUNK));
    check("in_ready_done", {127'd0, in_ready}, 128'd0);
    held = out_data;
    for (int i = 0; i < hold; i++) begin
      if (i == 2) begin
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
      end
      if (i == 4) in_valid = 1'b0;
      @(posedge clk); #1;
      check("hold_valid", {127'd0, out_valid}, 128'd1);
      check("hold_data", out_data, held);
      check("hold_in_ready", {127'd0, in_ready}, 128'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_valid", {127'd0, out_valid}, 128'd0);
    check("release_in_ready", {127'd0, in_ready}, 128'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d;
    int           hold;
    for (int a = 0; a < 256; a++) begin
      logic [7:0] iv;
      iv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) iv = 8'(b);
      fwd_t[a] = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
    end
    for (int a = 0; a < 256; a++) inv_t[fwd_t[a]] = 8'(a);

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
`ifdef SUB_BYTES_INV_EN
    inv_mode = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_in_ready", {127'd0, in_ready}, 128'd1);
    check("rst_out_data", out_data, 128'd0);

    run_block(128'd0, {16{8'h63}}, 1'b0, 0);
    run_block(128'h193de3bea0f4e22b9ac68d2ae9f84808,
              128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 0);
    run_block({32'h000153ff, 96'd0}, {32'h637ced16, {12{8'h63}}}, 1'b0, 10);

    // Abort a block two edges after acceptance; nothing may come out of it.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_out_valid", {127'd0, out_valid}, 128'd0);
    check("abort_busy", {127'd0, busy}, 128'd0);
    check("abort_in_ready", {127'd0, in_ready}, 128'd1);
    check("abort_out_data", out_data, 128'd0);
    rst = 1'b0;
    run_block(128'h193de3bea0f4e22b9ac68d2ae9f84808,
              128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 0);

    for (int n = 0; n < 25; n++) begin
      d    = {$urandom, $urandom, $urandom, $urandom};
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      run_block(d, model(d, 1'b0), 1'b0, hold);
    end

`ifdef SUB_BYTES_INV_EN
    run_block({16{8'h63}}, 128'd0, 1'b1, 0);
    run_block({8'h52, 8'h09, 112'd0}, {8'h48, 8'h40, {14{8'h52}}}, 1'b1, 0);
    for (int n = 0; n < 15; n++) begin
      bit inv;
      d   = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'($urandom_range(0, 1));
      run_block(d, model(d, inv), inv, ($urandom_range(0, 3) == 0) ? 3 : 0);
    end
`endif

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sub_bytes_seq.md
Name: sub_bytes_seq

Overview:
- Encrypt-side SubBytes engine: applies the forward AES S-box (FIPS-197) to all 16 bytes of a 128-bit state.
- Processes LANES bytes per cycle, using LANES forward S-box lookups.
- Valid/ready handshake on both sides; sits in the encryptor round datapath between AddRoundKey and ShiftRows.
- Counterpart of the decryptor's inverse S-box path.

Parameters:
- LANES, 4, bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- NCHUNK, 16/LANES (derived localparam, not overridable), cycles per block.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input state valid
- in_ready  out  1  engine can accept a state
- in_data  in  128  input state; byte 0 = [127:120], byte 15 = [7:0]
- out_valid  out  1  substituted state valid
- out_ready  in  1  downstream accepts output
- out_data  out  128  substituted state, same byte order
- busy  out  1  high while in BUSY state

Behaviour:
- Reset: synchronous on rst=1 at a clock edge.
  - Forces state IDLE and clears the chunk counter to 0.
  - Clears the internal state register and out_data to 128'h0.
  - After reset: out_valid=0, busy=0, in_ready=1.
  - Reset mid-BUSY or mid-DONE aborts the block; the result is discarded and never presented.
- State machine: IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_data into the work register, set counter=0, go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle, bytes counter*LANES .. counter*LANES+LANES-1 of the work register are replaced by S(byte), in place.
  - counter increments by 1. At counter==NCHUNK-1 the last chunk is written and the state goes to DONE.
- DONE:
  - out_valid=1; out_data = work register, held stable while out_ready=0.
  - On out_ready=1: go to IDLE, out_valid falls next cycle.
  - in_ready stays 0 in DONE; the block does not overlap blocks.
- Latency: out_valid rises exactly NCHUNK cycles after the accepting edge (LANES=4: 4 cycles; LANES=16: 1 cycle).
- Throughput: one block per NCHUNK+2 cycles when out_ready is held 1. That is accept, NCHUNK BUSY cycles, one DONE cycle, then IDLE again.
- in_data changes after the accept edge have no effect. in_valid while not in IDLE is ignored and is not lost; the upstream holds it per the handshake.
- out_data holds its last value in IDLE.
- S-box is purely combinational, byte in to byte out, with all 256 entries defined. There is no default/fallback value path.
- Counter width is clog2(NCHUNK), minimum 1 bit. The counter never exceeds NCHUNK-1 and wraps to 0 only via a new accept.

Optional Feature:
- Macro: SUB_BYTES_INV_EN.
- When defined:
  - Adds input port inv_mode (1 bit). It is sampled at the accepting edge and held for the whole block.
  - inv_mode=1 selects the inverse S-box lanes; inv_mode=0 selects the forward lanes.
  - This makes the unit shareable by the encryptor and the decryptor.
- When undefined:
  - No inv_mode port and no inverse S-box logic.
  - Forward substitution only.
- Timing and handshake are identical in both builds.

Test Plan:
1. Reset, then in_data=128'h00000000000000000000000000000000 with LANES=4 -> 4 cycles after accept, out_valid=1 and out_data=128'h63636363636363636363636363636363.
2. in_data=128'h193de3bea0f4e22b9ac68d2ae9f84808 (FIPS-197 App. B round 1) -> out_data=128'hd42711aee0bf98f1b8b45de51e415230. Checked for LANES=1, 4 and 16 with latency 16, 4 and 1 respectively.
3. Byte-order check: in_data=128'h0001_53ff followed by 96 zero bits, i.e. bytes 0..3 = 00,01,53,ff -> out bytes 0..3 = 63,7c,ed,16 and remaining bytes = 63.
4. Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid and out_data stay stable and in_ready=0 throughout. A second in_valid pulse during this time is not accepted. out_ready=1 -> IDLE next cycle, in_ready=1.
5. Reset mid-op: assert rst 2 cycles after accept -> next cycle out_valid=0, busy=0, in_ready=1, out_data=0. A following block computes correctly.
6. SUB_BYTES_INV_EN defined, inv_mode=1, in_data=128'h63636363636363636363636363636363 -> out_data all 00. Then inv_mode=1 with in_data bytes 52,09 -> 48,40.
